// File: rtl/mem_dpram_arbiter.sv
// Two-master round-robin arbiter for a simple dual-port RAM.
// The write port and the read port each have their own arbiter. The read
// return tracks which master owns the read data, accounting for the
// one-cycle RAM read latency.

// Round-robin arbiter for two requesters. When both request, the winner is
// the one that was not granted last.
module mem_dpram_arbiter_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic       gnt_vld,
  output logic       gnt_idx,
  output logic [1:0] gnt
);
  logic pri;

  // Grant select: use the priority pointer on contention, otherwise the
  // single requester. All grants are forced to zero while in reset.
  always_comb begin
    gnt_idx = (req == 2'b11) ? pri : req[1];
    gnt_vld = (|req) & rst_n;
    gnt     = gnt_vld ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  end

  // Priority passes to the other master after each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pri <= 1'b0;
    else if (gnt_vld) pri <= ~gnt_idx;
  end
endmodule

module mem_dpram_arbiter #(
  parameter int WIDTH_AD = 10,
  parameter int WIDTH_DA = 32,
  parameter int WIDTH_DS = WIDTH_DA/8
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                M0_WREQ,
  input  logic [WIDTH_AD-1:0] M0_WADDR,
  input  logic [WIDTH_DA-1:0] M0_WDATA,
  input  logic [WIDTH_DS-1:0] M0_WSTRB,
  output logic                M0_WACK,
  input  logic                M0_RREQ,
  input  logic [WIDTH_AD-1:0] M0_RADDR,
  input  logic [WIDTH_DS-1:0] M0_RSTRB,
  output logic                M0_RACK,
  output logic                M0_RVALID,
  output logic [WIDTH_DA-1:0] M0_RDATA,
  input  logic                M1_WREQ,
  input  logic [WIDTH_AD-1:0] M1_WADDR,
  input  logic [WIDTH_DA-1:0] M1_WDATA,
  input  logic [WIDTH_DS-1:0] M1_WSTRB,
  output logic                M1_WACK,
  input  logic                M1_RREQ,
  input  logic [WIDTH_AD-1:0] M1_RADDR,
  input  logic [WIDTH_DS-1:0] M1_RSTRB,
  output logic                M1_RACK,
  output logic                M1_RVALID,
  output logic [WIDTH_DA-1:0] M1_RDATA,
  output logic [WIDTH_AD-1:0] WADDR,
  output logic [WIDTH_DA-1:0] WDATA,
  output logic [WIDTH_DS-1:0] WSTRB,
  output logic                WEN,
  output logic [WIDTH_AD-1:0] RADDR,
  output logic [WIDTH_DS-1:0] RSTRB,
  output logic                REN,
  input  logic [WIDTH_DA-1:0] RDATA
);
  // Index 0 is the write port, index 1 is the read port.
  logic [1:0][1:0] req;
  logic [1:0][1:0] gnt;
  logic [1:0]      gnt_vld;
  logic [1:0]      gnt_idx;
  logic            rvld;
  logic            rsel;

  assign req[0] = {M1_WREQ, M0_WREQ};
  assign req[1] = {M1_RREQ, M0_RREQ};

  for (genvar p = 0; p < 2; p++) begin : g_port
    mem_dpram_arbiter_rr u_rr (
      .clk    (CLK),
      .rst_n  (RESETn),
      .req    (req[p]),
      .gnt_vld(gnt_vld[p]),
      .gnt_idx(gnt_idx[p]),
      .gnt    (gnt[p])
    );
  end

  // Steer the granted master onto each RAM port. The address passes through
  // whole, including the byte-offset bits.
  always_comb begin
    {M1_WACK, M0_WACK} = gnt[0];
    {M1_RACK, M0_RACK} = gnt[1];
    WEN   = gnt_vld[0];
    WADDR = gnt_idx[0] ? M1_WADDR : M0_WADDR;
    WDATA = gnt_idx[0] ? M1_WDATA : M0_WDATA;
    WSTRB = gnt_idx[0] ? M1_WSTRB : M0_WSTRB;
    REN   = gnt_vld[1];
    RADDR = gnt_idx[1] ? M1_RADDR : M0_RADDR;
    RSTRB = gnt_idx[1] ? M1_RSTRB : M0_RSTRB;
  end

  // Record the owner of the read issued this cycle. Its data comes back
  // on the next cycle. Reset discards any read still in flight.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rvld <= 1'b0;
      rsel <= 1'b0;
    end else begin
      rvld <= REN;
      rsel <= gnt_idx[1];
    end
  end

  // RAM data goes to both masters. RVALID tells each master whether the
  // data is its own.
  always_comb begin
    M0_RVALID = rvld & ~rsel;
    M1_RVALID = rvld &  rsel;
    M0_RDATA  = RDATA;
    M1_RDATA  = RDATA;
  end
endmodule
